// File: rtl/led_status_arb.sv
// Priority arbiter for the drive-bay amber/green status LED pair.
// Picks the highest active status, holds lower-priority downgrades for HOLD_SEC ticks.
module led_status_arb #(
  parameter int HOLD_SEC   = 2,
  parameter int LOCATE_SEC = 15,
  parameter int LAMP_SEC   = 3
) (
  input  logic       sysclk_i,
  input  logic       rst_i,
  input  logic       clk_1hz_i,
  input  logic       clk_2hz_i,
  input  logic       clk_4hz_i,
  input  logic       clk_4hz_500ms_i,
  input  logic       fault_req_i,
  input  logic       warn_req_i,
  input  logic       rebuild_req_i,
  input  logic       act_req_i,
  input  logic       pwr_ok_i,
  input  logic       locate_pulse_i,
  input  logic       locate_clr_i,
  input  logic       lamp_test_i,
  output logic       led_amber_o,
  output logic       led_green_o,
  output logic [2:0] state_o,
  output logic       locate_act_o
);

  // state   | meaning
  // OFF     | nothing requested, both LEDs dark
  // PWR     | power good, steady green
  // ACT     | activity, green blinks on clk_4hz_500ms
  // REBUILD | rebuild in progress, green blinks 2 Hz
  // LOCATE  | locate window, amber blinks 4 Hz
  // WARN    | warning, amber blinks 1 Hz
  // FAULT   | fault, steady amber
  // LAMP    | lamp test, both lit
  typedef enum logic [2:0] {
    ST_OFF, ST_PWR, ST_ACT, ST_REBUILD, ST_LOCATE, ST_WARN, ST_FAULT, ST_LAMP
  } state_t;

  localparam int HW = $clog2(HOLD_SEC + 1);
  localparam int LW = $clog2(LOCATE_SEC + 1);
  localparam int TW = $clog2(LAMP_SEC + 1);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [LW-1:0] loc_cnt_q, loc_cnt_d;
  logic [TW-1:0] lamp_cnt_q, lamp_cnt_d;
  logic          loc_act_q, loc_act_d;
  logic          lamp_act_q, lamp_act_d;
  logic          tick_prev_q;
  logic          amber_q, amber_d;
  logic          green_q, green_d;

  logic          tick;
  logic          lamp_expire;
  logic [7:0]    req;
  logic [2:0]    tgt;

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q     <= ST_OFF;
      hold_q      <= '0;
      loc_cnt_q   <= '0;
      lamp_cnt_q  <= '0;
      loc_act_q   <= 1'b0;
      lamp_act_q  <= 1'b0;
      tick_prev_q <= 1'b0;
      amber_q     <= 1'b0;
      green_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      loc_cnt_q   <= loc_cnt_d;
      lamp_cnt_q  <= lamp_cnt_d;
      loc_act_q   <= loc_act_d;
      lamp_act_q  <= lamp_act_d;
      tick_prev_q <= clk_1hz_i;
      amber_q     <= amber_d;
      green_q     <= green_d;
    end
  end

  always_comb begin
    tick       = clk_1hz_i & ~tick_prev_q;
    loc_act_d  = loc_act_q;
    loc_cnt_d  = loc_cnt_q;
    lamp_act_d = lamp_act_q;
    lamp_cnt_d = lamp_cnt_q;

    if (locate_clr_i) begin
      loc_act_d = 1'b0;
      loc_cnt_d = '0;
    end else if (locate_pulse_i) begin
      loc_act_d = 1'b1;
      loc_cnt_d = LW'(LOCATE_SEC);
    end else if (loc_act_q) begin
      if (loc_cnt_q == '0) loc_act_d = 1'b0;
      else if (tick)       loc_cnt_d = loc_cnt_q - LW'(1);
    end

    if (lamp_test_i) begin
      lamp_act_d = 1'b1;
      lamp_cnt_d = TW'(LAMP_SEC);
    end else if (lamp_act_q) begin
      if (lamp_cnt_q == '0) lamp_act_d = 1'b0;
      else if (tick)        lamp_cnt_d = lamp_cnt_q - TW'(1);
    end

    // The lamp request is dropped in its final cycle so the display
    // leaves LAMP together with the window, ignoring any pending hold.
    lamp_expire = lamp_act_q && (lamp_cnt_q == '0) && !lamp_test_i;

    req = {lamp_act_q & ~lamp_expire, fault_req_i, warn_req_i, loc_act_q,
           rebuild_req_i, act_req_i, pwr_ok_i, 1'b1};
    tgt = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (req[i]) tgt = 3'(i);
    end

    state_d = state_q;
    if (tgt > state_q || (tgt < state_q && (hold_q == '0 || lamp_expire)))
      state_d = state_t'(tgt);

    hold_d = hold_q;
    if (state_d != state_q)        hold_d = HW'(HOLD_SEC);
    else if (tick && hold_q != '0) hold_d = hold_q - HW'(1);

    amber_d = 1'b0;
    green_d = 1'b0;
    case (state_q)
      ST_OFF:     ;
      ST_PWR:     green_d = 1'b1;
      ST_ACT:     green_d = clk_4hz_500ms_i;
      ST_REBUILD: green_d = clk_2hz_i;
      ST_LOCATE:  amber_d = clk_4hz_i;
      ST_WARN:    amber_d = clk_1hz_i;
      ST_FAULT:   amber_d = 1'b1;
      ST_LAMP: begin
        amber_d = 1'b1;
        green_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o      = state_q;
  assign locate_act_o = loc_act_q;
  assign led_amber_o  = amber_q;
  assign led_green_o  = green_q;

endmodule
